tpa_reg_arbiter: RTL and testbench
==================================

// Module: tpa_reg_arbiter
// PURPOSE
//  Arbitrates two requesters onto one shared single-port 2^AW x DW register RAM:
//  port A = parallel cfg register master; port B = request side of the two-wire slave.
//  Sequences RAM enable/write/read timing and returns read data.
//  Resolves same-address write collisions deterministically: port A wins.
// PARAMETERS
//  AW  8   address width (RAM depth 2^AW)
//  DW  16  data width
// PORTS
//  clk        in   1   clock; all state on rising edge
//  reset_n    in   1   asynchronous, active-low reset
//  a_req      in   1   port A request; held with a_cmd/a_addr/a_wdata stable until a_ack
//  a_cmd      in   1   1=write, 0=read
//  a_addr     in   AW  register address
//  a_wdata    in   DW  write data
//  a_ack      out  1   one-cycle completion pulse
//  a_rdata    out  DW  read data, valid while a_ack=1 for a read
//  b_req/b_cmd/b_addr/b_wdata/b_ack/b_rdata  same as port A, for port B
//  b_drop     out  1   pulses with b_ack when B write was discarded by collision
//  mem_en     out  1   RAM access enable
//  mem_we     out  1   RAM write enable (meaningful only with mem_en)
//  mem_addr   out  AW  RAM address
//  mem_wdata  out  DW  RAM write data
//  mem_rdata  in   DW  RAM read data, valid the cycle after mem_en=1,mem_we=0
//  busy       out  1   1 whenever FSM is not IDLE
//  drop_cnt   out  8   count of B drops, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, last_grant=B (so A wins first tie), drop_cnt=0.
//  Reset mid-operation aborts any access; no ack is issued for it.
//  Cycle c = interval after edge c. All outputs are registered.
//  FSM: IDLE, WRITE, RD_ISSUE, RD_WAIT, RD_DONE.
//  Arbitration runs at every edge where FSM is IDLE, WRITE or RD_DONE.
//  At an arbitration edge, a port's req is ignored if that port's ack is high in the
//  ending cycle. This one-edge holdoff gives the requester time to drop or change req.
//  - one eligible req -> grant it.
//  - both eligible -> grant the port not in last_grant (round-robin); update last_grant.
//  - none -> IDLE.
//  Collision: both eligible, both write, a_addr==b_addr.
//  - grant A regardless of last_grant; last_grant=A.
//  - b_ack=1 and b_drop=1 in the same cycle as a_ack; no B RAM write; drop_cnt++ (sat).
//  Write granted at edge 0:
//  - cycle 0: WRITE, mem_en=1, mem_we=1, mem_addr/mem_wdata=granted port values, ack=1.
//  Read granted at edge 0:
//  - cycle 0: RD_ISSUE, mem_en=1, mem_we=0.
//  - cycle 1: RD_WAIT, mem_en=0.
//  - edge 2: rdata<=mem_rdata; cycle 2: RD_DONE, ack=1.
//  Latency from sampled req: write ack 0 cycles after grant edge; read ack 2 cycles after.
//  Throughput: back-to-back writes on alternating ports give 1 access/cycle.
//  mem_en=0 in IDLE, RD_WAIT, RD_DONE. a_rdata/b_rdata hold their last value between reads.
//  Read/write to the same address granted on consecutive edges follows grant order;
//  the RAM is write-first across cycles.
//  drop_cnt saturates at 255; further drops still pulse b_drop.
// TESTING
//  Write A[0x12]=0xBEEF, then read via B 0x12 -> b_ack at read grant+2, b_rdata=0xBEEF.
//  A and B write 0x40 same edge (A=0x1111, B=0x2222) -> a_ack,b_ack,b_drop same cycle;
//    one mem write; read 0x40=0x1111; drop_cnt=1.
//  A read 0x05, B write 0x06 same edge with last_grant=A -> B write first, then A read;
//    a_rdata correct; no mem_en in RD_WAIT.
//  A and B hold req high continuously (distinct addrs) -> grants strictly alternate
//    A,B,A,B; no port acked twice for one request.
//  Assert reset_n low in RD_WAIT -> no ack; all outputs 0; next read completes normally.
//  Force 256 collisions -> drop_cnt reaches 255 and stays; b_drop still pulses each time.

Source files
------------

// File: rtl/tpa_reg_arbiter.sv
// Two-port arbiter in front of one single-port register RAM.
// Port A is the parallel cfg master, port B the two-wire slave request side.
module tpa_reg_arbiter #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          i_a_req,
   input  logic          i_a_cmd,
   input  logic [AW-1:0] i_a_addr,
   input  logic [DW-1:0] i_a_wdata,
   output logic          o_a_ack,
   output logic [DW-1:0] o_a_rdata,
   input  logic          i_b_req,
   input  logic          i_b_cmd,
   input  logic [AW-1:0] i_b_addr,
   input  logic [DW-1:0] i_b_wdata,
   output logic          o_b_ack,
   output logic [DW-1:0] o_b_rdata,
   output logic          o_b_drop,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata,
   output logic          o_busy,
   output logic [7:0]    o_drop_cnt
);

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRdIssue,
      StRdWait,
      StRdDone
   } state_e;

   state_e        r_state, w_state_d;
   logic          r_last_a, w_last_a_d;
   logic          r_rd_port_a, w_rd_port_a_d;
   logic          r_a_ack, w_a_ack_d;
   logic          r_b_ack, w_b_ack_d;
   logic          r_b_drop, w_b_drop_d;
   logic [DW-1:0] r_a_rdata, w_a_rdata_d;
   logic [DW-1:0] r_b_rdata, w_b_rdata_d;
   logic          r_mem_en, w_mem_en_d;
   logic          r_mem_we, w_mem_we_d;
   logic [AW-1:0] r_mem_addr, w_mem_addr_d;
   logic [DW-1:0] r_mem_wdata, w_mem_wdata_d;
   logic          r_busy, w_busy_d;
   logic [7:0]    r_drop_cnt, w_drop_cnt_d;

   logic          w_a_elig, w_b_elig;
   logic          w_collide;
   logic          w_grant_a, w_grant_b;
   logic          w_sel_cmd;
   logic [AW-1:0] w_sel_addr;
   logic [DW-1:0] w_sel_wdata;

   // A port whose ack is high in the ending cycle is held off for this edge.
   assign w_a_elig  = i_a_req & ~r_a_ack;
   assign w_b_elig  = i_b_req & ~r_b_ack;
   assign w_collide = w_a_elig & w_b_elig & i_a_cmd & i_b_cmd & (i_a_addr == i_b_addr);

   // Grant only meaningful in IDLE/WRITE/RD_DONE; the case below gates it.
   assign w_grant_a   = w_a_elig & (~w_b_elig | w_collide | ~r_last_a);
   assign w_grant_b   = w_b_elig & ~w_grant_a;
   assign w_sel_cmd   = w_grant_a ? i_a_cmd   : i_b_cmd;
   assign w_sel_addr  = w_grant_a ? i_a_addr  : i_b_addr;
   assign w_sel_wdata = w_grant_a ? i_a_wdata : i_b_wdata;

   always_comb begin
      w_state_d     = r_state;
      w_last_a_d    = r_last_a;
      w_rd_port_a_d = r_rd_port_a;
      w_a_ack_d     = 1'b0;
      w_b_ack_d     = 1'b0;
      w_b_drop_d    = 1'b0;
      w_a_rdata_d   = r_a_rdata;
      w_b_rdata_d   = r_b_rdata;
      w_mem_en_d    = 1'b0;
      w_mem_we_d    = 1'b0;
      w_mem_addr_d  = r_mem_addr;
      w_mem_wdata_d = r_mem_wdata;
      w_drop_cnt_d  = r_drop_cnt;

      unique case (r_state)
         StRdIssue: begin
            w_state_d = StRdWait;
         end
         StRdWait: begin
            w_state_d = StRdDone;
            if (r_rd_port_a) begin
               w_a_rdata_d = i_mem_rdata;
               w_a_ack_d   = 1'b1;
            end else begin
               w_b_rdata_d = i_mem_rdata;
               w_b_ack_d   = 1'b1;
            end
         end
         default: begin
            if (w_grant_a || w_grant_b) begin
               w_last_a_d   = w_grant_a;
               w_mem_en_d   = 1'b1;
               w_mem_we_d   = w_sel_cmd;
               w_mem_addr_d = w_sel_addr;
               if (w_sel_cmd) begin
                  w_state_d     = StWrite;
                  w_mem_wdata_d = w_sel_wdata;
                  w_a_ack_d     = w_grant_a;
                  // Collision: B is acked alongside A but its write is discarded.
                  w_b_ack_d     = w_grant_b | w_collide;
                  w_b_drop_d    = w_collide;
                  if (w_collide && (r_drop_cnt != 8'hFF)) begin
                     w_drop_cnt_d = r_drop_cnt + 8'd1;
                  end
               end else begin
                  w_state_d     = StRdIssue;
                  w_rd_port_a_d = w_grant_a;
               end
            end else begin
               w_state_d = StIdle;
            end
         end
      endcase

      w_busy_d = (w_state_d != StIdle);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state     <= StIdle;
         r_last_a    <= 1'b0;
         r_rd_port_a <= 1'b0;
         r_a_ack     <= 1'b0;
         r_b_ack     <= 1'b0;
         r_b_drop    <= 1'b0;
         r_a_rdata   <= '0;
         r_b_rdata   <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
         r_drop_cnt  <= 8'd0;
      end else begin
         r_state     <= w_state_d;
         r_last_a    <= w_last_a_d;
         r_rd_port_a <= w_rd_port_a_d;
         r_a_ack     <= w_a_ack_d;
         r_b_ack     <= w_b_ack_d;
         r_b_drop    <= w_b_drop_d;
         r_a_rdata   <= w_a_rdata_d;
         r_b_rdata   <= w_b_rdata_d;
         r_mem_en    <= w_mem_en_d;
         r_mem_we    <= w_mem_we_d;
         r_mem_addr  <= w_mem_addr_d;
         r_mem_wdata <= w_mem_wdata_d;
         r_busy      <= w_busy_d;
         r_drop_cnt  <= w_drop_cnt_d;
      end
   end

   assign o_a_ack     = r_a_ack;
   assign o_a_rdata   = r_a_rdata;
   assign o_b_ack     = r_b_ack;
   assign o_b_rdata   = r_b_rdata;
   assign o_b_drop    = r_b_drop;
   assign o_mem_en    = r_mem_en;
   assign o_mem_we    = r_mem_we;
   assign o_mem_addr  = r_mem_addr;
   assign o_mem_wdata = r_mem_wdata;
   assign o_busy      = r_busy;
   assign o_drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_tpa_reg_arbiter.sv
// Directed bench for tpa_reg_arbiter: per-cycle vector table plus reset and
// drop-saturation sequences, against a behavioural single-port RAM.
module tb_tpa_reg_arbiter;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        a_req = 0, a_cmd = 0, b_req = 0, b_cmd = 0;
   logic [7:0]  a_addr = 0, b_addr = 0;
   logic [15:0] a_wdata = 0, b_wdata = 0;
   logic        a_ack, b_ack, b_drop, mem_en, mem_we, busy;
   logic [15:0] a_rdata, b_rdata, mem_wdata;
   logic [15:0] mem_rdata = 16'h0;
   logic [7:0]  mem_addr, drop_cnt;
   logic [15:0] ram [256];

   int n_checks = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tpa_reg_arbiter #(.AW(8), .DW(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .i_a_req(a_req), .i_a_cmd(a_cmd), .i_a_addr(a_addr), .i_a_wdata(a_wdata),
      .o_a_ack(a_ack), .o_a_rdata(a_rdata),
      .i_b_req(b_req), .i_b_cmd(b_cmd), .i_b_addr(b_addr), .i_b_wdata(b_wdata),
      .o_b_ack(b_ack), .o_b_rdata(b_rdata), .o_b_drop(b_drop),
      .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
      .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata),
      .o_busy(busy), .o_drop_cnt(drop_cnt)
   );

   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata <= ram[mem_addr];
      end
   end

   typedef struct {
      logic        ar, ac; logic [7:0] aa; logic [15:0] ad;
      logic        br, bc; logic [7:0] ba; logic [15:0] bd;
      logic        ak, bk, dr, en, we; logic [7:0] ma; logic [15:0] mw;
      logic        bsy; logic [15:0] ard, brd;
   } vec_t;

   vec_t vt[22];

   function automatic vec_t mk(
      input logic ar, input logic ac, input logic [7:0] aa, input logic [15:0] ad,
      input logic br, input logic bc, input logic [7:0] ba, input logic [15:0] bd,
      input logic ak, input logic bk, input logic dr, input logic en, input logic we,
      input logic [7:0] ma, input logic [15:0] mw, input logic bsy,
      input logic [15:0] ard, input logic [15:0] brd);
      vec_t v;
      v.ar = ar; v.ac = ac; v.aa = aa; v.ad = ad;
      v.br = br; v.bc = bc; v.ba = ba; v.bd = bd;
      v.ak = ak; v.bk = bk; v.dr = dr; v.en = en; v.we = we;
      v.ma = ma; v.mw = mw; v.bsy = bsy; v.ard = ard; v.brd = brd;
      return v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input logic ar, input logic ac, input logic [7:0] aa,
                        input logic [15:0] ad, input logic br, input logic bc,
                        input logic [7:0] ba, input logic [15:0] bd);
      a_req = ar; a_cmd = ac; a_addr = aa; a_wdata = ad;
      b_req = br; b_cmd = bc; b_addr = ba; b_wdata = bd;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] act, exp;
      int          cyc;
      logic [7:0]  exp_cnt;

      for (int i = 0; i < 256; i++) ram[i] = 16'h0;
      ram[8'h05] = 16'h5A5A;

      // ar ac aa ad | br bc ba bd | ak bk dr en we ma mw bsy ard brd
      vt[0]  = mk(1,1,8'h12,16'hBEEF, 0,0,8'h00,16'h0000, 1,0,0,1,1,8'h12,16'hBEEF,1,16'h0000,16'h0000);
      vt[1]  = mk(0,0,8'h00,16'h0000, 1,0,8'h12,16'h0000, 0,0,0,1,0,8'h12,16'h0000,1,16'h0000,16'h0000);
      vt[2]  = mk(0,0,8'h00,16'h0000, 1,0,8'h12,16'h0000, 0,0,0,0,0,8'h00,16'h0000,1,16'h0000,16'h0000);
      vt[3]  = mk(0,0,8'h00,16'h0000, 1,0,8'h12,16'h0000, 0,1,0,0,0,8'h00,16'h0000,1,16'h0000,16'hBEEF);
      vt[4]  = mk(0,0,8'h00,16'h0000, 1,0,8'h12,16'h0000, 0,0,0,0,0,8'h00,16'h0000,0,16'h0000,16'hBEEF);
      vt[5]  = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0,0,8'h00,16'h0000,0,16'h0000,16'hBEEF);
      vt[6]  = mk(1,1,8'h40,16'h1111, 1,1,8'h40,16'h2222, 1,1,1,1,1,8'h40,16'h1111,1,16'h0000,16'hBEEF);
      vt[7]  = mk(1,1,8'h40,16'h1111, 1,1,8'h40,16'h2222, 0,0,0,0,0,8'h00,16'h0000,0,16'h0000,16'hBEEF);
      vt[8]  = mk(1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,1,0,8'h40,16'h0000,1,16'h0000,16'hBEEF);
      vt[9]  = mk(1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0,0,8'h00,16'h0000,1,16'h0000,16'hBEEF);
      vt[10] = mk(1,0,8'h40,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,0,0,8'h00,16'h0000,1,16'h1111,16'hBEEF);
      vt[11] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0,0,8'h00,16'h0000,0,16'h1111,16'hBEEF);
      vt[12] = mk(1,0,8'h05,16'h0000, 1,1,8'h06,16'hABCD, 0,1,0,1,1,8'h06,16'hABCD,1,16'h1111,16'hBEEF);
      vt[13] = mk(1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,1,0,8'h05,16'h0000,1,16'h1111,16'hBEEF);
      vt[14] = mk(1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0,0,8'h00,16'h0000,1,16'h1111,16'hBEEF);
      vt[15] = mk(1,0,8'h05,16'h0000, 0,0,8'h00,16'h0000, 1,0,0,0,0,8'h00,16'h0000,1,16'h5A5A,16'hBEEF);
      vt[16] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0,0,8'h00,16'h0000,0,16'h5A5A,16'hBEEF);
      vt[17] = mk(1,1,8'h10,16'hA001, 1,1,8'h20,16'hB001, 0,1,0,1,1,8'h20,16'hB001,1,16'h5A5A,16'hBEEF);
      vt[18] = mk(1,1,8'h10,16'hA001, 1,1,8'h21,16'hB002, 1,0,0,1,1,8'h10,16'hA001,1,16'h5A5A,16'hBEEF);
      vt[19] = mk(1,1,8'h11,16'hA002, 1,1,8'h21,16'hB002, 0,1,0,1,1,8'h21,16'hB002,1,16'h5A5A,16'hBEEF);
      vt[20] = mk(1,1,8'h11,16'hA002, 1,1,8'h22,16'hB003, 1,0,0,1,1,8'h11,16'hA002,1,16'h5A5A,16'hBEEF);
      vt[21] = mk(0,0,8'h00,16'h0000, 0,0,8'h00,16'h0000, 0,0,0,0,0,8'h00,16'h0000,0,16'h5A5A,16'hBEEF);

      #1;
      chk("reset_outputs",
          64'({a_ack, b_ack, b_drop, mem_en, mem_we, busy, drop_cnt, a_rdata, b_rdata}), 64'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         drive(vt[i].ar, vt[i].ac, vt[i].aa, vt[i].ad, vt[i].br, vt[i].bc, vt[i].ba, vt[i].bd);
         step();
         act = 64'({a_ack, b_ack, b_drop, mem_en, mem_we, busy, a_rdata, b_rdata});
         exp = 64'({vt[i].ak, vt[i].bk, vt[i].dr, vt[i].en, vt[i].we, vt[i].bsy,
                    vt[i].ard, vt[i].brd});
         chk($sformatf("vec%0d_ctrl", i), act, exp);
         if (vt[i].en) chk($sformatf("vec%0d_addr", i), 64'(mem_addr), 64'(vt[i].ma));
         if (vt[i].en && vt[i].we)
            chk($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(vt[i].mw));
      end
      @(negedge clk);
      drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);

      chk("ram_40_a_wins", 64'(ram[8'h40]), 64'h1111);
      chk("ram_06",        64'(ram[8'h06]), 64'hABCD);
      chk("ram_10",        64'(ram[8'h10]), 64'hA001);
      chk("ram_20",        64'(ram[8'h20]), 64'hB001);
      chk("ram_22_unwritten", 64'(ram[8'h22]), 64'h0);
      chk("drop_cnt_one",  64'(drop_cnt), 64'd1);

      // Reset asserted while a read sits in RD_WAIT.
      @(negedge clk);
      drive(1, 0, 8'h12, 16'h0, 0, 0, 8'h00, 16'h0);
      step();
      chk("rst_rd_issue", 64'({mem_en, mem_we}), 64'b10);
      step();
      chk("rst_rd_wait", 64'({mem_en, busy}), 64'b01);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_mid_outputs",
          64'({a_ack, b_ack, b_drop, mem_en, mem_we, busy, drop_cnt, a_rdata, b_rdata}), 64'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("rst_no_ack%0d", i), 64'({a_ack, busy}), 64'd0);
      end
      @(negedge clk);
      reset_n = 1'b1;
      cyc = 0;
      while (!a_ack && cyc < 10) begin
         step();
         cyc++;
      end
      chk("rst_read_latency", 64'(cyc), 64'd3);
      chk("rst_read_data", 64'(a_rdata), 64'hBEEF);
      @(negedge clk);
      drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
      step();

      // Saturating drop counter; b_drop must keep pulsing past saturation.
      exp_cnt = 8'd0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         drive(1, 1, 8'h80, 16'(i), 1, 1, 8'h80, ~16'(i));
         step();
         if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
         chk($sformatf("coll%0d_acks", i), 64'({a_ack, b_ack, b_drop, mem_we}), 64'b1111);
         chk($sformatf("coll%0d_cnt", i), 64'(drop_cnt), 64'(exp_cnt));
         @(negedge clk);
         drive(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0);
         step();
      end
      chk("coll_ram_80", 64'(ram[8'h80]), 64'h00FF);
      chk("coll_cnt_final", 64'(drop_cnt), 64'd255);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
